// File: rtl/mem_copy_engine.sv
// Word-serial memory copy initiator: reads src, writes dst, one word at a time.
// It requests the shared memory port with mem_req and drives it only while granted.
module mem_copy_engine #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [31:0]      src,
  input  logic [31:0]      dst,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             mem_req,
  input  logic             mem_gnt,
  output logic             mem_we,
  output logic [31:0]      mem_a,
  output logic [31:0]      mem_wd,
  input  logic [31:0]      mem_rd
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_READ,
    S_WRITE,
    S_FIN
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [31:0]      r_sa;
  logic [31:0]      r_da;
  logic [31:0]      r_data;
  logic [LEN_W-1:0] r_cnt;
  logic             r_err;

  logic w_misaligned;
  logic w_accept;
  logic w_rd_fire;
  logic w_wr_fire;

  // Misalignment outranks len=0, so it is the only source of the err flag.
  assign w_misaligned = (src[1:0] != 2'b00) || (dst[1:0] != 2'b00);
  assign w_accept     = (r_state == S_IDLE) && start;
  assign mem_wd       = r_data;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b1;
    done         = 1'b0;
    err          = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_a        = 32'h0;
    w_rd_fire    = 1'b0;
    w_wr_fire    = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (w_misaligned || (len == '0)) begin
            w_state_next = S_FIN;
          end else begin
            w_state_next = S_REQ;
          end
        end
      end
      S_REQ: begin
        mem_req = 1'b1;
        if (mem_gnt) begin
          w_state_next = S_READ;
        end
      end
      S_READ: begin
        mem_req = 1'b1;
        mem_a   = r_sa;
        if (mem_gnt) begin
          w_rd_fire    = 1'b1;
          w_state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        mem_req = 1'b1;
        mem_a   = r_da;
        mem_we  = mem_gnt;
        if (mem_gnt) begin
          w_wr_fire    = 1'b1;
          w_state_next = (r_cnt == LEN_W'(1)) ? S_FIN : S_READ;
        end
      end
      S_FIN: begin
        done         = 1'b1;
        err          = r_err;
        w_state_next = S_IDLE;
      end
      default: begin
        busy         = 1'b0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sa   <= 32'h0;
      r_da   <= 32'h0;
      r_data <= 32'h0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_sa  <= src;
        r_da  <= dst;
        r_cnt <= len;
        r_err <= w_misaligned;
      end
      if (w_rd_fire) begin
        r_data <= mem_rd;
        r_sa   <= r_sa + 32'd4;
      end
      if (w_wr_fire) begin
        r_da  <= r_da + 32'd4;
        r_cnt <= r_cnt - LEN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Randomized bench for mem_copy_engine: a 64-word aliased memory plus a sequential
// copy model that predicts write order, final memory contents and done latency.
module tb_mem_copy_engine;
  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic [31:0]      src = 32'h0;
  logic [31:0]      dst = 32'h0;
  logic [LEN_W-1:0] len = '0;
  logic             busy, done, err, mem_req, mem_we;
  logic             mem_gnt = 1'b0;
  logic [31:0]      mem_a, mem_wd, mem_rd;

  logic [31:0] mem [64];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // 256-byte memory; byte addresses alias modulo 256, which keeps 32-bit wrap coherent.
  assign mem_rd = mem[mem_a[7:2]];
  always @(posedge clk) if (mem_we) mem[mem_a[7:2]] <= mem_wd;

  mem_copy_engine #(.LEN_W(LEN_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .src(src), .dst(dst), .len(len),
    .busy(busy), .done(done), .err(err), .mem_req(mem_req), .mem_gnt(mem_gnt),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // gmode: 0 = grant always high, 1 = random grant, 2 = grant low in cycles 3..5
  task automatic run_cmd(input logic [31:0] s, input logic [31:0] d, input int n,
                         input int gmode, input bit repulse);
    logic [31:0] exp_mem [64];
    logic [31:0] wq_a [$];
    logic [31:0] wq_d [$];
    logic [31:0] a_s, a_d;
    bit rejected;
    int done_cyc, stalls, wr_idx, req_cycles, busy_bad, we_bad, wtime_bad, cyc, mism, exp_cyc;
    rejected = (s[1:0] != 2'b00) || (d[1:0] != 2'b00);
    done_cyc = -1; stalls = 0; wr_idx = 0; req_cycles = 0;
    busy_bad = 0; we_bad = 0; wtime_bad = 0; mism = 0;
    foreach (exp_mem[i]) exp_mem[i] = mem[i];
    if (!rejected) begin
      for (int i = 0; i < n; i++) begin
        a_s = s + 32'(4 * i);
        a_d = d + 32'(4 * i);
        exp_mem[a_d[7:2]] = exp_mem[a_s[7:2]];
        wq_a.push_back(a_d);
        wq_d.push_back(exp_mem[a_d[7:2]]);
      end
    end

    start = 1'b1; src = s; dst = d; len = n[LEN_W-1:0];
    @(posedge clk); #1;
    start = 1'b0; src = $urandom; dst = $urandom; len = LEN_W'($urandom);
    cyc = 1;
    while (done_cyc < 0 && cyc < 300) begin
      case (gmode)
        0:       mem_gnt = 1'b1;
        1:       mem_gnt = ($urandom_range(0, 3) != 0);
        default: mem_gnt = !(cyc >= 3 && cyc <= 5);
      endcase
      start = (repulse && cyc == 3);
      if (start) begin
        src = s + 32'h40; dst = d + 32'h20; len = LEN_W'(1);
      end
      #1;
      if (!busy) busy_bad++;
      if (mem_req) req_cycles++;
      if (mem_req && !mem_gnt) stalls++;
      if (mem_we && !mem_gnt) we_bad++;
      if (mem_we) begin
        if (wr_idx < wq_a.size()) begin
          check("wr_addr", mem_a, wq_a[wr_idx]);
          check("wr_data", mem_wd, wq_d[wr_idx]);
          if (gmode == 0 && cyc != 3 + 2 * wr_idx) wtime_bad++;
        end else begin
          we_bad++;
        end
        wr_idx++;
      end
      if (done) begin
        done_cyc = cyc;
        check("err", {31'b0, err}, {31'b0, rejected});
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    mem_gnt = 1'b0;

    exp_cyc = (rejected || n == 0) ? 1 : 2 * n + 2 + stalls;
    check("done_cycle", done_cyc, exp_cyc);
    check("busy_after", {31'b0, busy}, 32'h0);
    check("done_after", {31'b0, done}, 32'h0);
    check("busy_during", busy_bad, 0);
    check("we_bad", we_bad, 0);
    check("n_writes", wr_idx, rejected ? 0 : n);
    check("wr_timing", wtime_bad, 0);
    if (rejected || n == 0) check("req_cycles", req_cycles, 0);
    foreach (mem[i]) if (mem[i] !== exp_mem[i]) mism++;
    check("mem_image", mism, 0);
    $display("cmd src=0x%08h dst=0x%08h len=%0d gmode=%0d rej=%0d done_cyc=%0d stalls=%0d",
             s, d, n, gmode, rejected, done_cyc, stalls);
  endtask

  // Reset asserted during the second READ of a 4-word copy.
  task automatic mid_reset(input logic [31:0] s, input logic [31:0] d);
    logic [31:0] exp_mem [64];
    logic [31:0] a_d;
    int saw_done, mism;
    saw_done = 0; mism = 0;
    foreach (exp_mem[i]) exp_mem[i] = mem[i];
    exp_mem[d[7:2]] = exp_mem[s[7:2]];
    start = 1'b1; src = s; dst = d; len = LEN_W'(4); mem_gnt = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      if (done) saw_done++;
      if (c == 4) reset_n = 1'b0;
      @(posedge clk); #1;
    end
    #1;
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_req", {31'b0, mem_req}, 32'h0);
    check("rst_we", {31'b0, mem_we}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    check("rst_a", mem_a, 32'h0);
    reset_n = 1'b1; mem_gnt = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (done) saw_done++;
    end
    check("rst_no_done", saw_done, 0);
    a_d = d + 32'd4;
    foreach (mem[i]) if (mem[i] !== exp_mem[i]) mism++;
    check("rst_mem", mism, 0);
    check("rst_second_word", mem[a_d[7:2]], exp_mem[a_d[7:2]]);
    $display("reset mid-copy src=0x%08h dst=0x%08h done_pulses=%0d", s, d, saw_done);
  endtask

  initial begin
    logic [31:0] rs, rd;
    foreach (mem[i]) mem[i] = $urandom;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_done", {31'b0, done}, 32'h0);
    check("reset_err", {31'b0, err}, 32'h0);
    check("reset_req", {31'b0, mem_req}, 32'h0);
    check("reset_we", {31'b0, mem_we}, 32'h0);
    check("reset_a", mem_a, 32'h0);
    check("reset_wd", mem_wd, 32'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    mem[4] = 32'h11; mem[5] = 32'h22; mem[6] = 32'h33;
    run_cmd(32'h10, 32'h80, 3, 0, 1'b0);
    check("plan_w0", mem[32], 32'h11);
    check("plan_w1", mem[33], 32'h22);
    check("plan_w2", mem[34], 32'h33);

    run_cmd(32'h20, 32'h40, 0, 0, 1'b0);
    run_cmd(32'h12, 32'h40, 2, 0, 1'b0);
    run_cmd(32'h10, 32'h81, 2, 0, 1'b0);
    run_cmd(32'h12, 32'h40, 0, 0, 1'b0);
    run_cmd(32'h00, 32'h30, 2, 2, 1'b0);
    run_cmd(32'h50, 32'h90, 2, 0, 1'b1);
    run_cmd(32'h60, 32'hA0, 2, 0, 1'b0);
    run_cmd(32'h10, 32'h18, 5, 1, 1'b0);
    run_cmd(32'hFFFF_FFF8, 32'h20, 4, 1, 1'b0);
    run_cmd(32'h30, 32'hFFFF_FFFC, 3, 0, 1'b0);

    mid_reset(32'h40, 32'hC0);
    @(posedge clk); #1;

    for (int k = 0; k < 24; k++) begin
      rs = $urandom & 32'h0000_00FC;
      rd = $urandom & 32'h0000_00FC;
      if ($urandom_range(0, 7) == 0) rs = rs | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) rd = rd | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 5) == 0) rs = rs | 32'hFFFF_FF00;
      if ($urandom_range(0, 5) == 0) rd = rd | 32'hFFFF_FF00;
      run_cmd(rs, rd, $urandom_range(0, 7), $urandom_range(0, 1), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
